// File: rtl/mux_4in_pkg.sv
// rtl/mux_4in_pkg.sv - shared widths, types and states for the 4-input mux path
//
// Shared by the mux datapath (MUX_4input) and the TDM receiver.
//   SEL_W   width of the select bus S
//   N_CH    number of mux inputs, which is also the width of the rebuilt word D

package mux_4in_pkg;

    localparam int SEL_W = 2;
    localparam int N_CH  = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_CH-1:0]  data_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/mux_4in_tdm_rx_if.sv
// rtl/mux_4in_tdm_rx_if.sv - signal bundle between the TDM receiver and its surroundings
//
// Signals:
//   run          level request to start or continue framing
//   Q            serial bit from the upstream mux output
//   S            select driven to the upstream mux
//   D            last completed word, bit i captured while S==i
//   frame_valid  one-cycle pulse when D updates
//   busy         high while the receiver is framing
//   glitch_err   sticky slot-stability error
// Modports:
//   master       surrounding logic: drives run and Q, observes the rest
//   slave        the receiver itself

interface mux_4in_tdm_rx_if;
    import mux_4in_pkg::*;

    logic  run;
    logic  Q;
    sel_t  S;
    data_t D;
    logic  frame_valid;
    logic  busy;
    logic  glitch_err;

    modport master (
        output run,
        output Q,
        input  S,
        input  D,
        input  frame_valid,
        input  busy,
        input  glitch_err
    );

    modport slave (
        input  run,
        input  Q,
        output S,
        output D,
        output frame_valid,
        output busy,
        output glitch_err
    );

endinterface

// File: rtl/mux_4in_slot_timer.sv
// rtl/mux_4in_slot_timer.sv - slot timer and select counter for the TDM receiver
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          high while the receiver is framing; timer and select hold when low
//   sel         current slot, driven out as the mux select
//   sample_stb  high during the cycle whose closing edge samples Q
//   slot_end    high during the last cycle of a slot (select advances on its edge)

module mux_4in_slot_timer
    import mux_4in_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int SAMPLE_AT   = SLOT_CYCLES / 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output sel_t sel,
    output logic sample_stb,
    output logic slot_end
);

    localparam int TW = $clog2(SLOT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(SLOT_CYCLES - 1);
    localparam logic [TW-1:0] SAMP = TW'(SAMPLE_AT);

    logic [TW-1:0] timer_q;
    sel_t          sel_q;

    // The receiver only leaves RUN at a frame boundary, where both counters
    // wrap to zero on the same edge, so holding while disabled keeps them at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            sel_q   <= '0;
        end else if (en) begin
            if (timer_q == LAST) begin
                timer_q <= '0;
                sel_q   <= sel_q + 1'b1;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign sel        = sel_q;
    assign sample_stb = en && (timer_q == SAMP);
    assign slot_end   = en && (timer_q == LAST);

endmodule

// File: rtl/mux_4in_tdm_rx.sv
// rtl/mux_4in_tdm_rx.sv - receive end of the 4-input mux path (select sweep, sample, frame rebuild)
//
// Steps the upstream mux select through slots 0..3, samples Q mid-slot into a
// shadow word and publishes the shadow word as D at each frame boundary with a
// one-cycle frame_valid pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_4in_tdm_rx_if.slave: run, Q in; S, D, frame_valid, busy, glitch_err out
//
// Build option MUX_4IN_TDM_RX_GLITCH_CHK_EN: when defined, Q is re-checked in
// the last cycle of each slot against the mid-slot sample; any difference sets
// the sticky glitch_err, cleared by reset or by entering RUN. When undefined,
// glitch_err is constant 0.

module mux_4in_tdm_rx
    import mux_4in_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int SAMPLE_AT   = SLOT_CYCLES / 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_4in_tdm_rx_if.slave     bus
);

    rx_state_e state_q;
    rx_state_e state_d;

    sel_t  sel;
    logic  sample_stb;
    logic  slot_end;
    logic  frame_end;

    data_t shadow_q;
    data_t d_q;
    logic  fv_q;

    mux_4in_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .SAMPLE_AT   (SAMPLE_AT)
    ) u_slot_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_q == RUN),
        .sel        (sel),
        .sample_stb (sample_stb),
        .slot_end   (slot_end)
    );

    assign frame_end = slot_end && (sel == sel_t'(N_CH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // run is only honoured as a stop request at a frame boundary, so a frame
    // that has started always completes and publishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.run) state_d = RUN;
            RUN:  if (frame_end && !bus.run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The shadow word is never cleared between frames; every bit is rewritten
    // before the next publish, so no stale bit can reach D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (sample_stb) begin
            shadow_q[sel] <= bus.Q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= '0;
            fv_q <= 1'b0;
        end else begin
            fv_q <= frame_end;
            if (frame_end) begin
                d_q <= shadow_q;
            end
        end
    end

`ifdef MUX_4IN_TDM_RX_GLITCH_CHK_EN
    logic glitch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 1'b0;
        end else if ((state_q == IDLE) && (state_d == RUN)) begin
            glitch_q <= 1'b0;
        end else if (slot_end && (bus.Q != shadow_q[sel])) begin
            glitch_q <= 1'b1;
        end
    end

    assign bus.glitch_err = glitch_q;
`else
    assign bus.glitch_err = 1'b0;
`endif

    assign bus.S           = sel;
    assign bus.D           = d_q;
    assign bus.frame_valid = fv_q;
    assign bus.busy        = (state_q == RUN);

endmodule

// File: tb/tb_mux_4in_tdm_rx.sv
// tb/tb_mux_4in_tdm_rx.sv - self-checking bench for mux_4in_tdm_rx driven by a behavioural 4-input mux

module tb_mux_4in_tdm_rx;
    import mux_4in_pkg::*;

    localparam int SLOT_CYCLES = 4;
    localparam int SAMPLE_AT   = 2;
    localparam int FRAME       = 4 * SLOT_CYCLES;
`ifdef MUX_4IN_TDM_RX_GLITCH_CHK_EN
    localparam bit GL_ON = 1'b1;
`else
    localparam bit GL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] mux_d = 4'b0000;

    always #5 clk = ~clk;

    mux_4in_tdm_rx_if bus ();

    assign bus.Q = mux_d[bus.S];

    mux_4in_tdm_rx #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .SAMPLE_AT   (SAMPLE_AT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts clocks since RUN entry within the current
    // frame; slot and phase fall out of plain division.
    bit         m_run;
    int         k;
    logic [3:0] m_d;
    logic [3:0] m_sh;
    bit         m_fv;
    bit         m_gl;

    always @(posedge clk or negedge rst_n) begin
        int slot;
        int ph;
        if (!rst_n) begin
            m_run = 0; k = 0; m_d = 4'b0; m_sh = 4'b0; m_fv = 0; m_gl = 0;
        end else begin
            m_fv = 0;
            if (!m_run) begin
                if (bus.run) begin
                    m_run = 1;
                    k = 0;
                    m_gl = 0;
                end
            end else begin
                slot = k / SLOT_CYCLES;
                ph   = k % SLOT_CYCLES;
                if (ph == SAMPLE_AT) m_sh[slot] = mux_d[slot];
                if (GL_ON && ph == SLOT_CYCLES - 1 && mux_d[slot] != m_sh[slot]) m_gl = 1;
                if (k == FRAME - 1) begin
                    m_d  = m_sh;
                    m_fv = 1;
                    k    = 0;
                    if (!bus.run) m_run = 0;
                end else begin
                    k = k + 1;
                end
            end
        end
    end

    bit mon_en = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("mon_S",    32'(bus.S), m_run ? 32'(k / SLOT_CYCLES) : 32'd0);
            check("mon_D",    32'(bus.D), 32'(m_d));
            check("mon_fv",   32'(bus.frame_valid), 32'(m_fv));
            check("mon_busy", 32'(bus.busy), 32'(m_run));
            check("mon_gl",   32'(bus.glitch_err), 32'(m_gl));
        end
    end

    task automatic wait_fv(input int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            @(negedge clk);
            cyc++;
            if (bus.frame_valid) break;
        end
        check("fv_seen", 32'(bus.frame_valid), 32'd1);
    endtask

    task automatic wait_sel(input logic [1:0] s, input int max);
        int cyc;
        cyc = 0;
        while (cyc < max && bus.S != s) begin
            @(negedge clk);
            cyc++;
        end
        check("sel_reached", 32'(bus.S), 32'(s));
    endtask

    typedef struct {
        logic [3:0] mux;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int cyc;

        vecs[0] = '{mux: 4'b1010, exp: 4'b1010};
        vecs[1] = '{mux: 4'b0110, exp: 4'b0110};
        for (int i = 0; i < 16; i++) vecs[i + 2] = '{mux: 4'(i), exp: 4'(i)};

        bus.run = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_S",    32'(bus.S), 32'd0);
        check("rst_D",    32'(bus.D), 32'd0);
        check("rst_fv",   32'(bus.frame_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_gl",   32'(bus.glitch_err), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // First frame: 16 clocks from RUN entry to the publish.
        mux_d   = vecs[0].mux;
        bus.run = 1'b1;
        wait_fv(40, cyc);
        check("first_latency", 32'(cyc), 32'(FRAME + 1));
        check("first_D",       32'(bus.D), 32'(vecs[0].exp));
        check("first_busy",    32'(bus.busy), 32'd1);

        // Back-to-back frames, new word applied at each boundary.
        for (int i = 1; i < 18; i++) begin
            mux_d = vecs[i].mux;
            wait_fv(40, cyc);
            check("period",  32'(cyc), 32'(FRAME));
            check("vec_D",   32'(bus.D), 32'(vecs[i].exp));
        end
        @(negedge clk);
        check("fv_width", 32'(bus.frame_valid), 32'd0);

        // run dropped mid-frame: frame still completes and publishes.
        mux_d = 4'b0011;
        wait_sel(2'd1, 40);
        bus.run = 1'b0;
        wait_fv(40, cyc);
        check("drop_D",    32'(bus.D), 32'h3);
        check("drop_busy", 32'(bus.busy), 32'd0);
        check("drop_S",    32'(bus.S), 32'd0);
        repeat (8) @(negedge clk);
        check("idle_busy2", 32'(bus.busy), 32'd0);
        check("idle_S2",    32'(bus.S), 32'd0);
        check("idle_fv2",   32'(bus.frame_valid), 32'd0);

        // Reset while S==2: immediate clear, clean restart.
        mux_d   = 4'b1100;
        bus.run = 1'b1;
        wait_sel(2'd2, 40);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_S",    32'(bus.S), 32'd0);
        check("mrst_D",    32'(bus.D), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_fv",   32'(bus.frame_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fv(40, cyc);
        check("rst_latency", 32'(cyc), 32'(FRAME + 1));
        check("rst_D",       32'(bus.D), 32'hC);

        // Q flips at the last cycle of slot 1.
        check("gl_pre", 32'(bus.glitch_err), 32'd0);
        repeat (SLOT_CYCLES + SLOT_CYCLES - 1) @(negedge clk);
        mux_d[1] = ~mux_d[1];
        repeat (3) @(negedge clk);
        check("gl_set", 32'(bus.glitch_err), 32'(GL_ON));
        wait_fv(40, cyc);
        wait_fv(40, cyc);
        check("gl_sticky", 32'(bus.glitch_err), 32'(GL_ON));
        bus.run = 1'b0;
        wait_fv(40, cyc);
        check("gl_idle",   32'(bus.glitch_err), 32'(GL_ON));
        bus.run = 1'b1;
        repeat (2) @(negedge clk);
        check("gl_clear", 32'(bus.glitch_err), 32'd0);

        // Random mux data and run toggling against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) mux_d = 4'($urandom);
            if ($urandom_range(0, 99) == 0) bus.run = ~bus.run;
        end

        @(negedge clk);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
